reg_mem_arbiter: RTL and testbench

- Shares one single-port reg_mem instance between two requesters: port 0 is instruction/operand fetch, port 1 is load/store.
- Each port uses a valid/ready request handshake; arbitration is round-robin.
- Drives the memory's addr/data_in/wen from registers and returns read data with a requester tag.
- After reset, optionally sequences a zero-clear of every memory location before accepting traffic.

---
 rtl/reg_mem_arbiter_pkg.sv | 16 +
 rtl/reg_mem_arbiter_if.sv | 48 ++++
 rtl/reg_mem_arbiter_rr_arb2.sv | 31 +++
 rtl/reg_mem_arbiter.sv | 94 +++++++++
 tb/tb_reg_mem_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_mem_arbiter_pkg.sv
// Shared definitions for the reg_mem arbiter slice: default widths, FSM states
// and requester port ids.
package reg_mem_arbiter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_BITS  = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

endpackage

// File: rtl/reg_mem_arbiter_if.sv
// Request/response and memory-side signals of the reg_mem arbiter.
// slave = arbiter view, master = requesters + memory view.
interface reg_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = reg_mem_arbiter_pkg::DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = reg_mem_arbiter_pkg::DEFAULT_ADDR_BITS
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_wen;
  logic [ADDR_BITS-1:0]  req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_wen;
  logic [ADDR_BITS-1:0]  req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;

  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req0_valid, req0_wen, req0_addr, req0_wdata,
    input  req1_valid, req1_wen, req1_addr, req1_wdata,
    input  mem_data_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata, init_done,
    output mem_addr, mem_data_in, mem_wen
  );

  modport master (
    output req0_valid, req0_wen, req0_addr, req0_wdata,
    output req1_valid, req1_wen, req1_addr, req1_wdata,
    output mem_data_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata, init_done,
    input  mem_addr, mem_data_in, mem_wen
  );

endinterface

// File: rtl/reg_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant. On a tie the port that did not win last is
// granted; last_grant updates whenever a grant is taken.
module reg_mem_arbiter_rr_arb2
  import reg_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  always_comb begin
    grant0 = en && valid0 && (!valid1 || (last_grant == PORT_LS));
    grant1 = en && valid1 && (!valid0 || (last_grant == PORT_FETCH));
  end

  // Ready equals grant, so any grant is an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_LS;
    end else if (grant0 || grant1) begin
      last_grant <= grant1 ? PORT_LS : PORT_FETCH;
    end
  end

endmodule

// File: rtl/reg_mem_arbiter.sv
// Shares one single-port reg_mem between fetch (port 0) and load/store
// (port 1), with optional zero-clear of the memory after reset.
module reg_mem_arbiter
  import reg_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  reg_mem_arbiter_if.slave bus
);

  state_t               state;
  logic [ADDR_BITS:0]   init_cnt;
  logic                 pend;
  logic                 pend_id;
  logic                 grant0;
  logic                 grant1;
  logic                 run_en;

  // init_done is set on the edge that enters RUN; qualifying with it keeps
  // ready low while reset is held even when the FSM resets straight to RUN.
  assign run_en = (state == ST_RUN) && bus.init_done;

  reg_mem_arbiter_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (run_en),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_rdata  = bus.mem_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt        <= '0;
      bus.mem_addr    <= '0;
      bus.mem_data_in <= '0;
      bus.mem_wen     <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.init_done   <= 1'b0;
      pend            <= 1'b0;
      pend_id         <= 1'b0;
    end else begin
      bus.rsp_valid <= pend;
      bus.rsp_id    <= pend_id;
      pend          <= 1'b0;
      unique case (state)
        ST_INIT: begin
          // Top counter bit set means address 2**ADDR_BITS-1 is being written now.
          if (init_cnt[ADDR_BITS]) begin
            state         <= ST_RUN;
            bus.init_done <= 1'b1;
            bus.mem_wen   <= 1'b0;
          end else begin
            bus.mem_wen     <= 1'b1;
            bus.mem_addr    <= init_cnt[ADDR_BITS-1:0];
            bus.mem_data_in <= '0;
            init_cnt        <= init_cnt + (ADDR_BITS+1)'(1);
          end
        end
        ST_RUN: begin
          bus.init_done <= 1'b1;
          if (grant0) begin
            bus.mem_addr    <= bus.req0_addr;
            bus.mem_data_in <= bus.req0_wdata;
            bus.mem_wen     <= bus.req0_wen;
            pend            <= !bus.req0_wen;
            pend_id         <= PORT_FETCH;
          end else if (grant1) begin
            bus.mem_addr    <= bus.req1_addr;
            bus.mem_data_in <= bus.req1_wdata;
            bus.mem_wen     <= bus.req1_wen;
            pend            <= !bus.req1_wen;
            pend_id         <= PORT_LS;
          end else begin
            bus.mem_wen <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Directed bench for reg_mem_arbiter with a behavioural 1-cycle-latency
// single-port memory attached to the mem_* side.
module tb_reg_mem_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned AB    = 5;
  localparam int unsigned DEPTH = 32;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_fail;

  reg_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  reg_mem_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_BITS     (AB),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_q;

  always @(posedge clk) begin
    if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_data_in;
      mem_q             <= '0;
    end else begin
      mem_q <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_data_out = mem_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [AB-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic w1, input logic [AB-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_wen = w0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_wen = w1; bus.req1_addr = a1; bus.req1_wdata = d1;
  endtask

  // Check readies for the current cycle, advance one edge, check the response.
  task automatic step(input string tag, input logic r0, input logic r1,
                      input logic rv, input logic rid, input logic [DW-1:0] rdata);
    #1;
    check({tag, ".ready0"}, 32'(bus.req0_ready), 32'(r0));
    check({tag, ".ready1"}, 32'(bus.req1_ready), 32'(r1));
    @(posedge clk); #1;
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      check({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(rid));
      check({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(rdata));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".mem_wen"}, 32'(bus.mem_wen), 32'(0));
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(0));
    check({tag, ".mem_data_in"}, 32'(bus.mem_data_in), 32'(0));
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(0));
    check({tag, ".init_done"}, 32'(bus.init_done), 32'(0));
    check({tag, ".ready0"}, 32'(bus.req0_ready), 32'(0));
    check({tag, ".ready1"}, 32'(bus.req1_ready), 32'(0));
  endtask

  // Expects n clear writes (req0_valid held high); a full run also checks RUN entry.
  task automatic init_run(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s.wen[%0d]", tag, i), 32'(bus.mem_wen), 32'(1));
      check($sformatf("%s.addr[%0d]", tag, i), 32'(bus.mem_addr), i);
      check($sformatf("%s.data[%0d]", tag, i), 32'(bus.mem_data_in), 32'(0));
      check($sformatf("%s.ready0[%0d]", tag, i), 32'(bus.req0_ready), 32'(0));
      check($sformatf("%s.done[%0d]", tag, i), 32'(bus.init_done), 32'(0));
    end
    if (n == DEPTH) begin
      @(posedge clk); #1;
      check({tag, ".init_done"}, 32'(bus.init_done), 32'(1));
      check({tag, ".wen_off"}, 32'(bus.mem_wen), 32'(0));
      check({tag, ".ready0_run"}, 32'(bus.req0_ready), 32'(1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check("reset.ready0_held", 32'(bus.req0_ready), 32'(0));

    rst_n = 1'b1;
    init_run("init", DEPTH);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // Port 0 write then read of address 3.
    drive(1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0, 5'd0, 8'h00);
    step("wr3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wr3.mem_wen", 32'(bus.mem_wen), 32'(1));
    check("wr3.mem_addr", 32'(bus.mem_addr), 32'(3));
    check("wr3.mem_data_in", 32'(bus.mem_data_in), 32'hA5);
    drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("rd3_acc", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rd3.mem_wen", 32'(bus.mem_wen), 32'(0));
    check("rd3.mem_addr", 32'(bus.mem_addr), 32'(3));
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("rd3_rsp", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    step("rd3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Preload addresses 1 and 2, leaving last_grant = 1.
    drive(1'b1, 1'b1, 5'd1, 8'h5A, 1'b0, 1'b0, 5'd0, 8'h00);
    step("wr1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd2, 8'hC3);
    step("wr2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Both ports hold reads for four cycles: grants 0,1,0,1.
    drive(1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00);
    step("rr0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("rr1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    step("rr2", 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);
    step("rr3", 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("rr4", 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3);
    step("rr5", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Port 1 back-to-back write/read of address 7.
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'h3C);
    step("b2b_wr", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00);
    step("b2b_rd", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("b2b_rsp", 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    step("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Same-address writes from both ports: port 0 first (last_grant = 1), port 1 wins the data.
    drive(1'b1, 1'b1, 5'd9, 8'h11, 1'b1, 1'b1, 5'd9, 8'h22);
    step("same_w0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd9, 8'h22);
    step("same_w1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("same_rd", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("same_rsp", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);

    // Reset in the middle of INIT at counter = 10, then a full restart.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    init_run("init_part", 10);
    check("mid_init.addr9", 32'(bus.mem_addr), 32'(9));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_init_rst");
    rst_n = 1'b1;
    init_run("reinit", DEPTH);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);

    // Reset one cycle after a read is accepted: the response is dropped.
    drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    step("drop_acc", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("drop_rst");
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("drop_rsp[%0d]", i), 32'(bus.rsp_valid), 32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
